// File: rtl/ad7903_spi_rx_pkg.sv
// Shared definitions for the AD7903 dual-channel SPI read engine.
// The sequencer compares o_spi_state against SPI_DONE to detect transfer completion.
package ad7903_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  localparam logic [2:0] SPI_DONE       = 3'd4;
  localparam int         DATA_WIDTH_DEF = 16;
  localparam int         SCK_HALF_DEF   = 3;

endpackage

// File: rtl/ad7903_spi_rx_if.sv
// Sequencer/ADC-facing signal bundle of the AD7903 read engine.
// slave = the read engine, master = sequencer plus ADC pins.
interface ad7903_spi_rx_if
  import ad7903_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  i_spi_start;
  logic                  o_spi_sck;
  logic                  i_spi_sdo_a;
  logic                  i_spi_sdo_b;
  logic [DATA_WIDTH-1:0] o_adc_data_a;
  logic [DATA_WIDTH-1:0] o_adc_data_b;
  logic                  o_adc_valid;
  logic [2:0]            o_spi_state;
  logic                  o_start_miss;

  modport slave (
    input  i_spi_start, i_spi_sdo_a, i_spi_sdo_b,
    output o_spi_sck, o_adc_data_a, o_adc_data_b, o_adc_valid, o_spi_state, o_start_miss
  );

  modport master (
    output i_spi_start, i_spi_sdo_a, i_spi_sdo_b,
    input  o_spi_sck, o_adc_data_a, o_adc_data_b, o_adc_valid, o_spi_state, o_start_miss
  );
endinterface

// File: rtl/ad7903_spi_rx_sck_gen.sv
// SCK generator: registered clock with SCK_HALF-cycle low and high phases while enabled.
// rise_o/fall_o flag the i_clk edge at which sck_o is about to go high/low.
module spi_sck_gen #(
  parameter int SCK_HALF = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int            CW      = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(SCK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tc;

  assign tc = (cnt_q == '0);

  // Disabled: hold SCK low with the counter preloaded, so the first phase is a full low half.
  always_comb begin
    cnt_d = HALF_M1;
    sck_d = 1'b0;
    if (en_i) begin
      sck_d = sck_q ^ tc;
      cnt_d = tc ? HALF_M1 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= HALF_M1;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = en_i & tc & ~sck_q;
  assign fall_o = en_i & tc & sck_q;
endmodule

// File: rtl/ad7903_spi_rx.sv
// AD7903 SPI read engine: on start, clocks in DATA_WIDTH bits from both SDO lines MSB-first.
// Channel B capture is built only with AD7903_RX_DUAL_EN; otherwise o_adc_data_b is tied to 0.
// IDLE=0 wait start | SETUP=1 SCK-low lead time | SHIFT=2 clock bits | HOLD=3 settle | DONE=4 publish
module ad7903_spi_rx
  import ad7903_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SCK_HALF   = SCK_HALF_DEF
) (
  input logic            i_clk,
  input logic            i_rst,
  ad7903_spi_rx_if.slave bus
);
  localparam int            TW       = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] SETUP_M1 = TW'(SCK_HALF - 1);
  localparam logic [BW-1:0] BITS_M1  = BW'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  sck, sck_rise, sck_fall, shift_en, setup_entry;
  logic [DATA_WIDTH-1:0] shift_a_q, data_a_q;
  logic                  valid_q, miss_q;

  assign shift_en    = (state_q == SHIFT);
  assign setup_entry = (state_q == IDLE) && bus.i_spi_start;

  spi_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .en_i   (shift_en),
    .sck_o  (sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        tmr_d = SETUP_M1;
        if (bus.i_spi_start) state_d = SETUP;
      end
      SETUP: begin
        bit_d = BITS_M1;
        if (tmr_q == '0) state_d = SHIFT;
        else             tmr_d   = tmr_q - 1'b1;
      end
      SHIFT: begin
        // A bit period ends on its falling edge; the last one closes the transfer.
        if (sck_fall) begin
          if (bit_q == '0) state_d = HOLD;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tmr_q     <= SETUP_M1;
      bit_q     <= BITS_M1;
      shift_a_q <= '0;
      data_a_q  <= '0;
      valid_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      miss_q  <= bus.i_spi_start && (state_q != IDLE);
      valid_q <= (state_q == HOLD);
      if (setup_entry)   shift_a_q <= '0;
      else if (sck_rise) shift_a_q <= {shift_a_q[DATA_WIDTH-2:0], bus.i_spi_sdo_a};
      if (state_q == HOLD) data_a_q <= shift_a_q;
    end
  end

`ifdef AD7903_RX_DUAL_EN
  logic [DATA_WIDTH-1:0] shift_b_q, data_b_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_b_q <= '0;
      data_b_q  <= '0;
    end else begin
      if (setup_entry)   shift_b_q <= '0;
      else if (sck_rise) shift_b_q <= {shift_b_q[DATA_WIDTH-2:0], bus.i_spi_sdo_b};
      if (state_q == HOLD) data_b_q <= shift_b_q;
    end
  end

  assign bus.o_adc_data_b = data_b_q;
`else
  assign bus.o_adc_data_b = '0;
`endif

  assign bus.o_spi_sck    = sck;
  assign bus.o_adc_data_a = data_a_q;
  assign bus.o_adc_valid  = valid_q;
  assign bus.o_spi_state  = state_q;
  assign bus.o_start_miss = miss_q;
endmodule

// File: tb/tb_ad7903_spi_rx.sv
// Directed bench for ad7903_spi_rx: SCK_HALF=3 and SCK_HALF=1 instances fed by a simple ADC model.
// Offset n counts falling i_clk edges after the edge that samples the start strobe (n=1 is SETUP).
module tb_ad7903_spi_rx;
  import ad7903_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  ad7903_spi_rx_if #(.DATA_WIDTH(16)) b3 ();
  ad7903_spi_rx_if #(.DATA_WIDTH(16)) b1 ();

  ad7903_spi_rx #(.DATA_WIDTH(16), .SCK_HALF(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(b3));
  ad7903_spi_rx #(.DATA_WIDTH(16), .SCK_HALF(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));

  // ADC model: MSB on the pin before the first SCK, next bit presented on each SCK fall.
  logic [15:0] adc3_a = '0, adc3_b = '0, adc1_a = '0, adc1_b = '0;
  int          rise3 = 0, rise1 = 0;
  logic [15:0] last_a = '0, last_b = '0;

  assign b3.i_spi_sdo_a = adc3_a[15];
  assign b3.i_spi_sdo_b = adc3_b[15];
  assign b1.i_spi_sdo_a = adc1_a[15];
  assign b1.i_spi_sdo_b = adc1_b[15];

  always @(negedge b3.o_spi_sck) begin
    adc3_a = {adc3_a[14:0], 1'b0};
    adc3_b = {adc3_b[14:0], 1'b1};
  end
  always @(negedge b1.o_spi_sck) begin
    adc1_a = {adc1_a[14:0], 1'b0};
    adc1_b = {adc1_b[14:0], 1'b1};
  end
  always @(posedge b3.o_spi_sck) rise3++;
  always @(posedge b1.o_spi_sck) rise1++;

  function automatic logic [15:0] exp_b(input logic [15:0] b);
`ifdef AD7903_RX_DUAL_EN
    return b;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SCK_HALF=3 transfer; a second start is raised at offset miss_at (0 = none).
  task automatic xfer3(input logic [15:0] a, input logic [15:0] b, input int miss_at);
    int   valid_cnt = 0, valid_n = 0, miss_cnt = 0, miss_n = 0;
    int   run = 0, bad = 0, first_rise = 0;
    logic prev = 1'b0;
    adc3_a = a;
    adc3_b = b;
    rise3  = 0;
    @(negedge clk);
    b3.i_spi_start = 1'b1;
    for (int n = 1; n <= 105; n++) begin
      @(negedge clk);
      if (b3.o_adc_valid)  begin valid_cnt++; valid_n = n; end
      if (b3.o_start_miss) begin miss_cnt++;  miss_n  = n; end
      if (n == 1)   chk("state_setup", b3.o_spi_state, 32'd1);
      if (n == 4)   chk("state_shift", b3.o_spi_state, 32'd2);
      if (n == 60)  chk("hold_data_a", b3.o_adc_data_a, last_a);
      if (n == 100) chk("state_hold", b3.o_spi_state, 32'd3);
      if (n == 101) chk("state_done", b3.o_spi_state, SPI_DONE);
      if (n == 102) chk("state_idle_after", b3.o_spi_state, 32'd0);
      if (n == 103) chk("state_idle_still", b3.o_spi_state, 32'd0);
      if (b3.o_spi_sck !== prev) begin
        if (prev)                 begin if (run != 3) bad++; end
        else if (first_rise != 0) begin if (run != 3) bad++; end
        else                      first_rise = n;
        run  = 1;
        prev = b3.o_spi_sck;
      end else begin
        run++;
      end
      b3.i_spi_start = (n == miss_at);
    end
    chk("valid_count", valid_cnt, 32'd1);
    chk("valid_offset", valid_n, 32'd101);
    chk("sck_rises", rise3, 32'd16);
    chk("first_rise", first_rise, 32'd7);
    chk("sck_phase", bad, 32'd0);
    chk("data_a", b3.o_adc_data_a, a);
    chk("data_b", b3.o_adc_data_b, exp_b(b));
    chk("miss_count", miss_cnt, (miss_at != 0) ? 32'd1 : 32'd0);
    chk("miss_offset", miss_n, (miss_at != 0) ? miss_at + 1 : 0);
    last_a = a;
    last_b = exp_b(b);
  endtask

  task automatic reset_mid3(input logic [15:0] a, input logic [15:0] b);
    int valid_cnt = 0;
    adc3_a = a;
    adc3_b = b;
    @(negedge clk);
    b3.i_spi_start = 1'b1;
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      b3.i_spi_start = 1'b0;
    end
    chk("sck_high_before_rst", b3.o_spi_sck, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_sck", b3.o_spi_sck, 32'd0);
    chk("rst_mid_state", b3.o_spi_state, 32'd0);
    chk("rst_mid_data_a", b3.o_adc_data_a, 32'd0);
    chk("rst_mid_data_b", b3.o_adc_data_b, 32'd0);
    chk("rst_mid_valid", b3.o_adc_valid, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    last_a = '0;
    last_b = '0;
    for (int n = 0; n < 110; n++) begin
      @(negedge clk);
      if (b3.o_adc_valid) valid_cnt++;
    end
    chk("rst_no_valid", valid_cnt, 32'd0);
    chk("rst_stays_idle", b3.o_spi_state, 32'd0);
  endtask

  task automatic xfer1(input logic [15:0] a, input logic [15:0] b);
    int   valid_cnt = 0, valid_n = 0, run = 0, bad = 0, first_rise = 0;
    logic prev = 1'b0;
    adc1_a = a;
    adc1_b = b;
    rise1  = 0;
    @(negedge clk);
    b1.i_spi_start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      b1.i_spi_start = 1'b0;
      if (b1.o_adc_valid) begin valid_cnt++; valid_n = n; end
      if (n == 34) chk("sh1_state_hold", b1.o_spi_state, 32'd3);
      if (n == 35) chk("sh1_state_done", b1.o_spi_state, SPI_DONE);
      if (b1.o_spi_sck !== prev) begin
        if (prev)                 begin if (run != 1) bad++; end
        else if (first_rise != 0) begin if (run != 1) bad++; end
        else                      first_rise = n;
        run  = 1;
        prev = b1.o_spi_sck;
      end else begin
        run++;
      end
    end
    chk("sh1_valid_count", valid_cnt, 32'd1);
    chk("sh1_valid_offset", valid_n, 32'd35);
    chk("sh1_sck_rises", rise1, 32'd16);
    chk("sh1_first_rise", first_rise, 32'd3);
    chk("sh1_sck_phase", bad, 32'd0);
    chk("sh1_data_a", b1.o_adc_data_a, a);
    chk("sh1_data_b", b1.o_adc_data_b, exp_b(b));
  endtask

  initial begin
    b3.i_spi_start = 1'b0;
    b1.i_spi_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sck", b3.o_spi_sck, 32'd0);
    chk("rst_state", b3.o_spi_state, 32'd0);
    chk("rst_valid", b3.o_adc_valid, 32'd0);
    chk("rst_miss", b3.o_start_miss, 32'd0);
    chk("rst_data_a", b3.o_adc_data_a, 32'd0);
    chk("rst_data_b", b3.o_adc_data_b, 32'd0);
    chk("rst_sh1_state", b1.o_spi_state, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer3(16'hA5C3, 16'h1234, 0);
    xfer3(16'h8000, 16'h7FFF, 0);
    xfer3(16'hFFFF, 16'h0000, 50);
    // Start raised while in DONE must count as a miss, not begin a new transfer.
    xfer3(16'h5A3C, 16'hC0DE, 101);
    reset_mid3(16'h0F0F, 16'hF0F0);
    xfer3(16'h1357, 16'h2468, 0);
    xfer1(16'h6E01, 16'h9BF7);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ad7903_spi_rx.md
# ad7903_spi_rx

SPI read engine for the AD7903 dual 16-bit ADC: on a one-cycle start strobe from the ADC conversion sequencer, it generates SCK, shifts in both SDO lines MSB-first, and presents the two samples with a one-cycle valid. It reports its state on a 3-bit bus whose value 4 (DONE) the sequencer uses as the transfer-complete indication. It sits between the conversion sequencer (CNV/start timing) and the PS-facing sample registers; system clock is 200 MHz.

## Interface
- DATA_WIDTH, 16: bits per channel per transfer
- SCK_HALF, 3: SCK half-period in i_clk cycles; must be ≥1 (3 → 33.3 MHz SCK)

- i_clk  in  1  system clock, 200 MHz
- i_rst  in  1  reset; asynchronous, active-high
- i_spi_start  in  1  one-cycle start strobe from sequencer
- o_spi_sck  out  1  SPI clock to ADC, idles low
- i_spi_sdo_a  in  1  ADC channel A serial data
- i_spi_sdo_b  in  1  ADC channel B serial data
- o_adc_data_a  out  DATA_WIDTH  last completed channel A sample
- o_adc_data_b  out  DATA_WIDTH  last completed channel B sample
- o_adc_valid  out  1  one-cycle pulse, data outputs updated this cycle
- o_spi_state  out  3  current state encoding
- o_start_miss  out  1  one-cycle pulse, start ignored because busy

## Operation
- States: IDLE=0, SETUP=1, SHIFT=2, HOLD=3, DONE=4; values 5–7 unreachable, recover to IDLE next cycle.
- IDLE: i_spi_start=1 → SETUP. Otherwise stay.
- SETUP: SCK_HALF cycles, SCK low (data-valid lead time after conversion) → SHIFT.
- SHIFT: DATA_WIDTH bit periods; each bit = SCK_HALF cycles low, then SCK_HALF cycles high. Both SDO inputs sampled at the i_clk edge where o_spi_sck goes 0→1; shifted into per-channel registers, MSB first. After the last high half → HOLD.
- HOLD: 1 cycle, SCK low, shift registers stable.
- DONE: 1 cycle; o_adc_data_a/b loaded from shift registers, o_adc_valid=1, o_spi_state=4 → IDLE.
- i_spi_start in any state other than IDLE: ignored, o_start_miss pulses next cycle, transfer in progress unaffected.
- Data outputs hold their value between DONE cycles; never partially updated.
- Shift registers cleared on entry to SETUP.

## Timing
- All outputs registered. Reset values: o_spi_sck=0, data outputs=0, o_adc_valid=0, o_start_miss=0, o_spi_state=0.
- Reset mid-transfer: immediate return to IDLE, SCK forced low, data outputs cleared, no valid pulse.
- Start sampled at edge T → SETUP from T+1; DONE cycle at T+2+SCK_HALF+2·SCK_HALF·DATA_WIDTH (defaults: T+101, 505 ns). Next start accepted from T+102.
- Exactly DATA_WIDTH SCK rising edges per transfer; SCK high time and low time each exactly SCK_HALF cycles.
- Start asserted in DONE cycle: counted as miss (not IDLE).

## Configuration
- AD7903_RX_DUAL_EN defined: both channels captured as above.
- Not defined: channel B logic removed; i_spi_sdo_b ignored, o_adc_data_b held 0; channel A timing and all state behaviour unchanged.

## Structure
- Package ad7903_pkg: state encodings IDLE..DONE, constant SPI_DONE=3'd4 (shared with the sequencer's completion check), default DATA_WIDTH.
- Sub-module spi_sck_gen: half-period counter producing o_spi_sck plus rise/fall strobes, enabled by SHIFT; top block owns FSM, bit counter, shift registers.

## Test plan
- Defaults, start at T, ADC model drives A=0xA5C3, B=0x1234 → 16 SCK rises, o_spi_state=4 and o_adc_valid=1 at T+101, data_a=0xA5C3, data_b=0x1234.
- Patterns 0x8000/0x7FFF and 0xFFFF/0x0000 → captured exactly, confirms MSB-first and no bit slip.
- Second start at T+50 → o_start_miss pulse at T+51, first transfer completes unchanged at T+101.
- i_rst pulse at T+40 → SCK low, state 0, data 0 immediately; no valid; fresh start afterwards completes normally.
- SCK_HALF=1 → SCK period 2 cycles, DONE at T+35; measure every high/low phase.
- AD7903_RX_DUAL_EN undefined, B toggling → o_adc_data_b stays 0, channel A correct.
